// File: rtl/altusoc_timer_pkg.sv
// rtl/altusoc_timer_pkg.sv - register map, control/status bit indices and byte-lane merge for the timer
package altusoc_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_CAPTURE  = 3'd5;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_PERIODIC   = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_CAP_IRQ_EN = 3;

    localparam int STATUS_PEND = 0;
    localparam int STATUS_CAPF = 1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/altusoc_timer_prescaler.sv
// rtl/altusoc_timer_prescaler.sv - prescale counter producing a one-cycle tick every PRESCALE+1 enabled cycles
module altusoc_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pscnt;

    assign tick = enable && (pscnt == prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            pscnt <= '0;
        end else if (clear) begin
            pscnt <= '0;
        end else if (enable) begin
            pscnt <= tick ? '0 : pscnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/altusoc_wb_timer.sv
// rtl/altusoc_wb_timer.sv - Wishbone classic timer: prescaled up-counter, compare match, level irq
// Optional input capture register built when ALTUSOC_TIMER_CAPTURE_EN is defined.
module altusoc_wb_timer
    import altusoc_timer_pkg::*;
#(
    parameter int          PRESCALE_W    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
`ifdef ALTUSOC_TIMER_CAPTURE_EN
    input  logic        i_capture,
`endif
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    logic [2:0]            reg_sel;
    logic                  wb_req;
    logic                  wb_wr;
    logic                  wr_ctrl;
    logic                  wr_prescale;
    logic                  wr_count;
    logic                  wr_compare;
    logic                  pend_clr;
    logic                  ctrl_en;
    logic                  ctrl_periodic;
    logic                  ctrl_irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           prescale_ext;
    logic [31:0]           prescale_wr;
    logic [31:0]           count;
    logic [31:0]           count_next;
    logic [31:0]           compare;
    logic                  pend;
    logic                  tick;
    logic                  match;
    logic                  irq_next;
    logic [31:0]           rd_data;
    logic                  unused_bits;

    assign reg_sel     = i_wb_adr[4:2];
    assign wb_req      = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wb_wr       = wb_req & i_wb_we;
    assign wr_ctrl     = wb_wr && (reg_sel == REG_CTRL) && i_wb_sel[0];
    assign wr_prescale = wb_wr && (reg_sel == REG_PRESCALE);
    assign wr_count    = wb_wr && (reg_sel == REG_COUNT) && (|i_wb_sel);
    assign wr_compare  = wb_wr && (reg_sel == REG_COMPARE);
    assign pend_clr    = wb_wr && (reg_sel == REG_STATUS) && i_wb_sel[0] && i_wb_dat[STATUS_PEND];

    always_comb begin
        prescale_ext = '0;
        prescale_ext[PRESCALE_W-1:0] = prescale;
    end

    assign prescale_wr = merge_bytes(prescale_ext, i_wb_dat, i_wb_sel);
    assign unused_bits = ^{i_wb_adr[1:0], prescale_wr};

    altusoc_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (i_clk),
        .rst      (i_rst),
        .enable   (ctrl_en),
        .clear    (wr_prescale),
        .prescale (prescale),
        .tick     (tick)
    );

    // A software COUNT write suppresses both the increment and the match check.
    assign count_next = count + 32'd1;
    assign match      = tick & ~wr_count & (count_next == compare);

`ifdef ALTUSOC_TIMER_CAPTURE_EN
    logic        cap_q;
    logic        cap_rise;
    logic        capf;
    logic        capf_clr;
    logic        ctrl_cap_irq_en;
    logic [31:0] capture;

    assign cap_rise = i_capture & ~cap_q;
    assign capf_clr = wb_wr && (reg_sel == REG_STATUS) && i_wb_sel[0] && i_wb_dat[STATUS_CAPF];
    assign irq_next = (pend & ctrl_irq_en) | (capf & ctrl_cap_irq_en);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_q           <= 1'b0;
            capf            <= 1'b0;
            ctrl_cap_irq_en <= 1'b0;
            capture         <= '0;
        end else begin
            cap_q <= i_capture;
            if (wr_ctrl) ctrl_cap_irq_en <= i_wb_dat[CTRL_CAP_IRQ_EN];
            if (cap_rise) begin
                capture <= count;
                capf    <= 1'b1;
            end else if (capf_clr) begin
                capf <= 1'b0;
            end
        end
    end
`else
    assign irq_next = pend & ctrl_irq_en;
`endif

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_EN]       = ctrl_en;
                rd_data[CTRL_PERIODIC] = ctrl_periodic;
                rd_data[CTRL_IRQ_EN]   = ctrl_irq_en;
`ifdef ALTUSOC_TIMER_CAPTURE_EN
                rd_data[CTRL_CAP_IRQ_EN] = ctrl_cap_irq_en;
`endif
            end
            REG_PRESCALE: rd_data = prescale_ext;
            REG_COUNT:    rd_data = count;
            REG_COMPARE:  rd_data = compare;
            REG_STATUS: begin
                rd_data[STATUS_PEND] = pend;
`ifdef ALTUSOC_TIMER_CAPTURE_EN
                rd_data[STATUS_CAPF] = capf;
`endif
            end
`ifdef ALTUSOC_TIMER_CAPTURE_EN
            REG_CAPTURE:  rd_data = capture;
`endif
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_ack      <= 1'b0;
            o_wb_rdt      <= '0;
            o_irq         <= 1'b0;
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            prescale      <= '0;
            count         <= '0;
            compare       <= RESET_COMPARE;
            pend          <= 1'b0;
        end else begin
            o_wb_ack <= wb_req;
            if (wb_req) o_wb_rdt <= rd_data;
            o_irq <= irq_next;

            if (wr_ctrl) begin
                ctrl_en       <= i_wb_dat[CTRL_EN];
                ctrl_periodic <= i_wb_dat[CTRL_PERIODIC];
                ctrl_irq_en   <= i_wb_dat[CTRL_IRQ_EN];
            end
            if (wr_prescale) prescale <= prescale_wr[PRESCALE_W-1:0];
            if (wr_compare) compare <= merge_bytes(compare, i_wb_dat, i_wb_sel);

            if (wr_count) begin
                count <= merge_bytes(count, i_wb_dat, i_wb_sel);
            end else if (tick) begin
                count <= (match & ctrl_periodic) ? '0 : count_next;
            end

            // A new match outranks a same-cycle write-1-to-clear.
            if (match) begin
                pend <= 1'b1;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_altusoc_wb_timer.sv
// tb/tb_altusoc_wb_timer.sv - self-checking bench for altusoc_wb_timer against a tick-arithmetic reference model
module tb_altusoc_wb_timer;

    localparam logic [2:0] R_CTRL = 3'd0, R_PRESCALE = 3'd1, R_COUNT = 3'd2,
                           R_COMPARE = 3'd3, R_STATUS = 3'd4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [4:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Reference model: timer enabled at edge m_e0 from count m_s; ticks fall on m_e0 + n*(m_p+1).
    int          m_e0 = 0;
    int          m_p = 0;
    logic [31:0] m_c = 32'hFFFF_FFFF;
    logic [31:0] m_s = 0;
    bit          m_per = 0, m_irqen = 0, m_on = 0;
    int          m_clr = 0;

    altusoc_wb_timer dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_stb (i_wb_stb),
`ifdef ALTUSOC_TIMER_CAPTURE_EN
        .i_capture(1'b0),
`endif
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .o_irq    (o_irq)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    function automatic longint ticks_at(int t);
        if (!m_on || t <= m_e0) return 0;
        return longint'((t - m_e0) / (m_p + 1));
    endfunction

    function automatic logic [31:0] count_at(int t);
        longint n = ticks_at(t);
        if (m_per) return 32'(n % longint'(m_c));
        return m_s + 32'(n);
    endfunction

    function automatic longint matches_at(int t);
        longint n = ticks_at(t);
        logic [31:0] first;
        if (m_per) return n / longint'(m_c);
        first = m_c - m_s;
        return (first != 0 && n >= longint'(first)) ? 1 : 0;
    endfunction

    function automatic bit pend_at(int t);
        return matches_at(t) > matches_at(m_clr - 1);
    endfunction

    function automatic logic irq_exp(int t);
        return m_irqen && m_on && pend_at(t - 1);
    endfunction

    task automatic wb_access(input bit we, input logic [2:0] r, input logic [31:0] dat,
                             input logic [3:0] sel, input int at_edge,
                             output logic [31:0] rd, output int edge_n);
        @(negedge i_clk);
        while (cyc_n + 1 < at_edge) @(negedge i_clk);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_adr = {r, 2'($urandom)};
        i_wb_dat = dat;
        i_wb_sel = sel;
        edge_n   = cyc_n + 1;
        @(posedge i_clk);
        #1;
        rd = o_wb_rdt;
        @(negedge i_clk);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] r, input logic [31:0] dat, input logic [3:0] sel,
                            output int edge_n);
        logic [31:0] dummy;
        wb_access(1'b1, r, dat, sel, 0, dummy, edge_n);
    endtask

    task automatic wb_read(input logic [2:0] r, output logic [31:0] rd, output int edge_n);
        wb_access(1'b0, r, 32'h0, 4'h0, 0, rd, edge_n);
    endtask

    task automatic do_reset;
        @(negedge i_clk);
        i_rst = 1'b1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        m_on = 0; m_s = 0; m_per = 0; m_irqen = 0; m_clr = 0; m_e0 = 0; m_p = 0;
        m_c = 32'hFFFF_FFFF;
    endtask

    task automatic start_timer(input int p, input logic [31:0] c, input logic [31:0] s,
                               input bit per, input bit ie);
        int e;
        do_reset();
        wb_write(R_PRESCALE, 32'(p), 4'hF, e);
        wb_write(R_COMPARE, c, 4'hF, e);
        wb_write(R_COUNT, s, 4'hF, e);
        wb_write(R_CTRL, {29'b0, ie, per, 1'b1}, 4'hF, e);
        m_p = p; m_c = c; m_s = s; m_per = per; m_irqen = ie;
        m_e0 = e; m_clr = e; m_on = 1;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic [31:0] exp_regs [8];
        int e;
        exp_regs = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        n_checks++;
        if (o_wb_ack !== 1'b0 || o_wb_rdt !== 32'h0 || o_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b rdt=%h irq=%b, expected 0/0/0", o_wb_ack, o_wb_rdt, o_irq);
        end
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = {R_COMPARE, 2'b00};
        #1;
        n_checks++;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL ack_early: got %b, expected 0", o_wb_ack); end
        @(posedge i_clk); #1;
        n_checks++;
        if (o_wb_ack !== 1'b1 || o_wb_rdt !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL ack_first: got ack=%b rdt=%h, expected 1/ffffffff", o_wb_ack, o_wb_rdt);
        end
        @(posedge i_clk); #1;
        n_checks++;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: got %b, expected 0", o_wb_ack); end
        @(posedge i_clk); #1;
        n_checks++;
        if (o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL ack_back_to_back: got %b, expected 1", o_wb_ack); end
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        for (int r = 0; r < 8; r++) begin
            wb_read(3'(r), rd, e);
            n_checks++;
            if (rd !== exp_regs[r]) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h, expected %h", r, rd, exp_regs[r]);
            end
        end
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_rst = 1'b1;
        @(posedge i_clk); #1;
        n_checks++;
        if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL ack_during_reset: got %b, expected 0", o_wb_ack); end
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_rst = 1'b0;
    endtask

    task automatic test_periodic;
        logic [31:0] rd;
        int e;
        start_timer(3, 32'd5, 32'd0, 1'b1, 1'b1);
        repeat (50) begin
            @(posedge i_clk); #1;
            n_checks++;
            if (o_irq !== irq_exp(cyc_n)) begin
                n_fail++; $display("FAIL periodic_irq@%0d: got %b, expected %b", cyc_n, o_irq, irq_exp(cyc_n));
            end
        end
        for (int k = 0; k < 6; k++) begin
            wb_read(k[0] ? R_STATUS : R_COUNT, rd, e);
            n_checks++;
            if (rd !== (k[0] ? {31'b0, pend_at(e - 1)} : count_at(e - 1))) begin
                n_fail++; $display("FAIL periodic_read%0d: got %h, expected %h", k, rd,
                                   k[0] ? {31'b0, pend_at(e - 1)} : count_at(e - 1));
            end
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] rd;
        int e;
        start_timer(0, 32'd2, 32'd0, 1'b0, 1'b1);
        repeat (6) begin
            @(posedge i_clk); #1;
            n_checks++;
            if (o_irq !== irq_exp(cyc_n)) begin
                n_fail++; $display("FAIL oneshot_irq@%0d: got %b, expected %b", cyc_n, o_irq, irq_exp(cyc_n));
            end
        end
        wb_read(R_COUNT, rd, e);
        n_checks++;
        if (rd !== count_at(e - 1)) begin
            n_fail++; $display("FAIL oneshot_count: got %h, expected %h", rd, count_at(e - 1));
        end
        wb_write(R_STATUS, 32'h1, 4'hF, e);
        m_clr = e;
        repeat (3) begin
            @(posedge i_clk); #1;
            n_checks++;
            if (o_irq !== irq_exp(cyc_n)) begin
                n_fail++; $display("FAIL oneshot_clr_irq@%0d: got %b, expected %b", cyc_n, o_irq, irq_exp(cyc_n));
            end
        end
        wb_read(R_STATUS, rd, e);
        n_checks++;
        if (rd !== {31'b0, pend_at(e - 1)}) begin
            n_fail++; $display("FAIL oneshot_status: got %h, expected %h", rd, {31'b0, pend_at(e - 1)});
        end
    endtask

    task automatic test_wrap;
        logic [31:0] rd;
        int e;
        start_timer(0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wb_read(R_STATUS, rd, e);
        n_checks++;
        if (rd !== {31'b0, pend_at(e - 1)}) begin
            n_fail++; $display("FAIL wrap_status: got %h, expected %h", rd, {31'b0, pend_at(e - 1)});
        end
        wb_read(R_COUNT, rd, e);
        n_checks++;
        if (rd !== count_at(e - 1)) begin
            n_fail++; $display("FAIL wrap_count: got %h, expected %h", rd, count_at(e - 1));
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd, exp_v, d, mask;
        logic [3:0] sel;
        int e;
        do_reset();
        wb_write(R_COMPARE, 32'h1122_3344, 4'hF, e);
        wb_write(R_COMPARE, 32'h0000_AB00, 4'b0010, e);
        wb_read(R_COMPARE, rd, e);
        n_checks++;
        if (rd !== 32'h1122_AB44) begin
            n_fail++; $display("FAIL byte_lane_compare: got %h, expected 1122ab44", rd);
        end
        exp_v = 32'h1122_AB44;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            sel = 4'($urandom_range(0, 15));
            mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            exp_v = (exp_v & ~mask) | (d & mask);
            wb_write(R_COMPARE, d, sel, e);
            wb_read(R_COMPARE, rd, e);
            n_checks++;
            if (rd !== exp_v) begin
                n_fail++; $display("FAIL byte_lane_rand%0d: got %h, expected %h", k, rd, exp_v);
            end
        end
        wb_write(R_PRESCALE, 32'hFFFF_FFFF, 4'hF, e);
        wb_read(R_PRESCALE, rd, e);
        n_checks++;
        if (rd !== 32'h0000_FFFF) begin
            n_fail++; $display("FAIL prescale_width: got %h, expected 0000ffff", rd);
        end
        wb_write(R_CTRL, 32'hFFFF_FFFF, 4'hF, e);
        wb_read(R_CTRL, rd, e);
        n_checks++;
        if (rd !== 32'h0000_0007) begin
            n_fail++; $display("FAIL ctrl_bits: got %h, expected 00000007", rd);
        end
    endtask

    task automatic test_collisions;
        logic [31:0] rd;
        int e;
        start_timer(1, 32'd4, 32'd0, 1'b0, 1'b1);
        wb_access(1'b1, R_STATUS, 32'h1, 4'hF, m_e0 + 8, rd, e);
        m_clr = e;
        wb_read(R_STATUS, rd, e);
        n_checks++;
        if (rd !== {31'b0, pend_at(e - 1)}) begin
            n_fail++; $display("FAIL w1c_vs_match: got %h, expected %h", rd, {31'b0, pend_at(e - 1)});
        end
        start_timer(0, 32'd10, 32'd0, 1'b0, 1'b0);
        wb_access(1'b1, R_COUNT, 32'h100, 4'hF, m_e0 + 10, rd, e);
        m_s = 32'h100; m_e0 = e; m_clr = e;
        wb_read(R_COUNT, rd, e);
        n_checks++;
        if (rd !== count_at(e - 1)) begin
            n_fail++; $display("FAIL count_write_vs_tick: got %h, expected %h", rd, count_at(e - 1));
        end
        wb_read(R_STATUS, rd, e);
        n_checks++;
        if (rd !== {31'b0, pend_at(e - 1)}) begin
            n_fail++; $display("FAIL count_write_no_match: got %h, expected %h", rd, {31'b0, pend_at(e - 1)});
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, c, s;
        int e, p, op;
        bit per, ie;
        for (int it = 0; it < 6; it++) begin
            p   = $urandom_range(0, 3);
            c   = 32'($urandom_range(1, 6));
            per = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            s   = per ? 32'd0 : c - 32'($urandom_range(1, 4));
            start_timer(p, c, s, per, ie);
            for (int k = 0; k < 8; k++) begin
                repeat ($urandom_range(0, 4)) begin
                    @(posedge i_clk); #1;
                    n_checks++;
                    if (o_irq !== irq_exp(cyc_n)) begin
                        n_fail++; $display("FAIL rand_irq it%0d@%0d: got %b, expected %b", it, cyc_n, o_irq, irq_exp(cyc_n));
                    end
                end
                op = $urandom_range(0, 2);
                if (op == 0) begin
                    wb_read(R_COUNT, rd, e);
                    n_checks++;
                    if (rd !== count_at(e - 1)) begin
                        n_fail++; $display("FAIL rand_count it%0d: got %h, expected %h", it, rd, count_at(e - 1));
                    end
                end else if (op == 1) begin
                    wb_read(R_STATUS, rd, e);
                    n_checks++;
                    if (rd !== {31'b0, pend_at(e - 1)}) begin
                        n_fail++; $display("FAIL rand_status it%0d: got %h, expected %h", it, rd, {31'b0, pend_at(e - 1)});
                    end
                end else begin
                    wb_write(R_STATUS, 32'h1, 4'hF, e);
                    m_clr = e;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_wrap();
        test_byte_lanes();
        test_collisions();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
